// File: rtl/dm_access.sv
// dm_access: MEM-stage data-memory sequencer with store lane steering and load extension.
// Optional DM_ACCESS_ALIGN_CHECK_EN enables misalignment/reserved-type exceptions.
module dm_access #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_en,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_exc
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_d;
   logic we_q, we_d;
   logic [2:0] type_q, type_d;
   logic [1:0] off_q, off_d;
   logic mem_en_q, mem_en_d;
   logic [3:0] mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic rsp_exc_q, rsp_exc_d;
   logic req_half, req_byte, illegal, ld_half, ld_byte, ld_signed;
   logic [7:0] lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_data;
   assign req_ready = reset_n && state_q == IDLE;
   assign req_half  = req_type == 3'd1 || req_type == 3'd2;
   assign req_byte  = req_type == 3'd3 || req_type == 3'd4;
`ifdef DM_ACCESS_ALIGN_CHECK_EN
   assign illegal = req_type > 3'd4 || (req_type == 3'd0 && req_addr[1:0] != 2'b00) || (req_half && req_addr[0]);
`else
   assign illegal = 1'b0;
`endif
   assign ld_half   = type_q == 3'd1 || type_q == 3'd2;
   assign ld_byte   = type_q == 3'd3 || type_q == 3'd4;
   assign ld_signed = type_q == 3'd1 || type_q == 3'd3;
   assign lane_b    = mem_rdata[{off_q, 3'b000} +: 8];
   assign lane_h    = mem_rdata[{off_q[1], 4'b0000} +: 16];
   assign ld_data   = ld_byte ? {{24{ld_signed & lane_b[7]}}, lane_b} :
                      ld_half ? {{16{ld_signed & lane_h[15]}}, lane_h} : mem_rdata;
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      type_d      = type_q;
      off_d       = off_q;
      mem_en_d    = mem_en_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_exc_d   = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d   = req_we;
            type_d = req_type;
            off_d  = req_addr[1:0];
            if (illegal) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_exc_d   = 1'b1;
            end else begin
               state_d     = ACCESS;
               mem_en_d    = 1'b1;
               mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
               mem_be_d    = !req_we ? 4'b0000 : req_byte ? 4'b0001 << req_addr[1:0] :
                             req_half ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
               mem_wdata_d = req_byte ? {4{req_wdata[7:0]}} : req_half ? {2{req_wdata[15:0]}} : req_wdata;
            end
         end
         ACCESS: if (mem_ack) begin
            state_d     = RESP;
            mem_en_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'd0 : ld_data;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         type_q      <= '0;
         off_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_exc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         type_q      <= type_d;
         off_q       <= off_d;
         mem_en_q    <= mem_en_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_exc_q   <= rsp_exc_d;
      end
   end
   assign mem_en    = mem_en_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_exc   = rsp_exc_q;
endmodule
